// File: rtl/hart_bus_arb_if.sv
// Bundle of hart-side and outer-memory-side signals around the shared memory arbiter.
// The slave view belongs to the arbiter; the master view to the hart array plus outer memory.
interface hart_bus_arb_if #(
  parameter int unsigned N_HARTS = 4,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 64
) ();
  logic [N_HARTS*ADDR_W-1:0] h_addr;
  logic [N_HARTS-1:0]        h_rd;
  logic [N_HARTS-1:0]        h_wr;
  logic [N_HARTS*LINE_W-1:0] h_data_out;
  logic [LINE_W-1:0]         h_data_in;
  logic [N_HARTS-1:0]        h_dv;
  logic [N_HARTS-1:0]        h_inv;
  logic [ADDR_W-1:0]         h_inv_addr;
  logic [N_HARTS-1:0]        h_amo_req;
  logic [N_HARTS-1:0]        h_amo_ack;
  logic [ADDR_W-1:0]         m_addr;
  logic                      m_rd;
  logic                      m_wr;
  logic [LINE_W-1:0]         m_data_out;
  logic [LINE_W-1:0]         m_data_in;
  logic                      m_dv;

  modport master (
    output h_addr, h_rd, h_wr, h_data_out, h_amo_req, m_data_in, m_dv,
    input  h_data_in, h_dv, h_inv, h_inv_addr, h_amo_ack, m_addr, m_rd, m_wr, m_data_out
  );

  modport slave (
    input  h_addr, h_rd, h_wr, h_data_out, h_amo_req, m_data_in, m_dv,
    output h_data_in, h_dv, h_inv, h_inv_addr, h_amo_ack, m_addr, m_rd, m_wr, m_data_out
  );
endinterface

// File: rtl/hart_bus_arb.sv
// Round-robin arbiter serialising N hart line reads/writes onto one outer memory port,
// with a single AMO lock and post-write line invalidation broadcast.
module hart_bus_arb #(
  parameter int unsigned N_HARTS = 4,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LINE_B  = $clog2(LINE_W / 8)
) (
  input logic            clk,
  input logic            rst,
  hart_bus_arb_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(N_HARTS);
  localparam logic [ADDR_W-1:0] LineMask = ~((ADDR_W'(1) << LINE_B) - ADDR_W'(1));

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, gnt_q, owner_q;
  logic [PtrW-1:0]     pick_idx, amo_idx;
  logic [N_HARTS-1:0]  req_vec, elig;
  logic                owner_v_q, wr_q;
  logic [ADDR_W-1:0]   addr_q, inv_addr_q;
  logic [LINE_W-1:0]   wdata_q, rdata_q;

  // First set bit at or above ptr, wrapping modulo N_HARTS.
  function automatic logic [PtrW-1:0] rr_pick(input logic [N_HARTS-1:0] req,
                                              input logic [PtrW-1:0]    ptr);
    logic [PtrW-1:0] res;
    logic            found;
    int unsigned     idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_HARTS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_HARTS) idx = idx - N_HARTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        res   = PtrW'(idx);
      end
    end
    return res;
  endfunction

  always_comb begin
    req_vec  = bus.h_rd | bus.h_wr;
    elig     = owner_v_q ? (req_vec & (N_HARTS'(1) << owner_q)) : req_vec;
    pick_idx = rr_pick(elig, rr_ptr_q);
    amo_idx  = rr_pick(bus.h_amo_req, rr_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|elig) state_d = StReq;
      StReq:   if (bus.m_dv) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.m_rd       = (state_q == StReq) && !wr_q;
    bus.m_wr       = (state_q == StReq) && wr_q;
    bus.h_dv       = '0;
    bus.h_inv      = '0;
    if (state_q == StResp) begin
      bus.h_dv = N_HARTS'(1) << gnt_q;
      if (wr_q) bus.h_inv = ~(N_HARTS'(1) << gnt_q);
    end
    bus.m_addr     = addr_q;
    bus.m_data_out = wdata_q;
    bus.h_data_in  = rdata_q;
    bus.h_inv_addr = inv_addr_q;
    bus.h_amo_ack  = owner_v_q ? (N_HARTS'(1) << owner_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      inv_addr_q <= '0;
      owner_v_q  <= 1'b0;
      owner_q    <= '0;
    end else begin
      if (state_q == StIdle && |elig) begin
        gnt_q   <= pick_idx;
        addr_q  <= bus.h_addr[pick_idx*ADDR_W +: ADDR_W];
        wr_q    <= bus.h_wr[pick_idx];
        wdata_q <= bus.h_data_out[pick_idx*LINE_W +: LINE_W];
      end
      if (state_q == StReq && bus.m_dv) begin
        if (wr_q) inv_addr_q <= addr_q & LineMask;
        else      rdata_q    <= bus.m_data_in;
      end
      if (state_q == StResp) begin
        rr_ptr_q <= (gnt_q == PtrW'(N_HARTS - 1)) ? '0 : gnt_q + PtrW'(1);
      end
      // Lock tracking runs independently of the transaction FSM.
      if (!owner_v_q && |bus.h_amo_req) begin
        owner_q   <= amo_idx;
        owner_v_q <= 1'b1;
      end else if (owner_v_q && !bus.h_amo_req[owner_q]) begin
        owner_v_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hart_bus_arb.sv
// Directed bench for hart_bus_arb: table of single transactions plus hand-written
// round-robin, AMO lock and mid-transaction reset sequences.
module tb_hart_bus_arb;

  localparam int unsigned NH = 4;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 64;

  localparam logic [LW-1:0] R0 = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] R1 = {8{32'h5A5A_1234}};
  localparam logic [LW-1:0] W1 = {8{32'hDEAD_0001}};
  localparam logic [LW-1:0] W2 = {8{32'hBEEF_0002}};
  localparam logic [LW-1:0] W3 = {8{32'hCAFE_0003}};
  localparam logic [LW-1:0] W4 = {8{32'hF00D_0004}};

  typedef struct {
    int            hart;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    logic [NH-1:0] exp_dv;
    logic [NH-1:0] exp_inv;
    logic [AW-1:0] exp_inv_addr;
    logic [LW-1:0] exp_hdi;
    int            exp_cyc;
    bit            exp_mwr;
  } vec_t;

  logic clk;
  logic rst;

  hart_bus_arb_if #(.N_HARTS(NH), .LINE_W(LW), .ADDR_W(AW)) bus ();

  hart_bus_arb #(.N_HARTS(NH), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int failures;
  int mem_lat;
  int mem_cnt;
  logic [LW-1:0] mem_rdata;
  logic [AW-1:0] cap_addr;
  logic [LW-1:0] cap_data;
  logic          cap_wr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outer memory model: m_dv arrives mem_lat cycles after the strobe rises.
  initial begin
    bus.m_dv      = 1'b0;
    bus.m_data_in = '0;
    mem_cnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !(bus.m_rd || bus.m_wr) || bus.m_dv) begin
        bus.m_dv = 1'b0;
        mem_cnt  = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt >= mem_lat + 1) begin
          bus.m_dv      = 1'b1;
          bus.m_data_in = mem_rdata;
        end
      end
    end
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_dv(output int cyc);
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.m_rd || bus.m_wr) begin
        cap_addr = bus.m_addr;
        cap_data = bus.m_data_out;
        cap_wr   = bus.m_wr;
      end
      if (bus.h_dv != '0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL dv_timeout: got no h_dv, expected a pulse within 64 cycles");
    end
  endtask

  task automatic clear_inputs();
    bus.h_addr     = '0;
    bus.h_rd       = '0;
    bus.h_wr       = '0;
    bus.h_data_out = '0;
    bus.h_amo_req  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    bus.h_addr[v.hart*AW +: AW]     = v.addr;
    bus.h_data_out[v.hart*LW +: LW] = v.wdata;
    bus.h_rd[v.hart] = v.rd;
    bus.h_wr[v.hart] = v.wr;
    mem_lat   = v.lat;
    mem_rdata = v.rdata;
    wait_dv(cyc);
    check($sformatf("v%0d_h_dv", n), bus.h_dv, v.exp_dv);
    check($sformatf("v%0d_h_inv", n), bus.h_inv, v.exp_inv);
    check($sformatf("v%0d_h_data_in", n), bus.h_data_in, v.exp_hdi);
    check($sformatf("v%0d_latency", n), cyc, v.exp_cyc);
    check($sformatf("v%0d_m_addr", n), cap_addr, v.addr);
    check($sformatf("v%0d_m_wr", n), cap_wr, v.exp_mwr);
    if (v.exp_mwr) check($sformatf("v%0d_m_data_out", n), cap_data, v.wdata);
    if (v.exp_inv != '0) check($sformatf("v%0d_inv_addr", n), bus.h_inv_addr, v.exp_inv_addr);
    bus.h_rd = '0;
    bus.h_wr = '0;
    @(posedge clk);
    #1;
    check($sformatf("v%0d_dv_pulse", n), bus.h_dv, 0);
    check($sformatf("v%0d_inv_pulse", n), bus.h_inv, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;
    mem_lat  = 1;
    mem_rdata = '0;
    cap_addr = '0;
    cap_data = '0;
    cap_wr   = 1'b0;

    // Fields: hart rd wr addr wdata lat rdata exp_dv exp_inv exp_inv_addr exp_hdi exp_cyc exp_mwr
    vecs[0] = '{2, 1'b1, 1'b0, 64'h1000, '0, 2, R0, 4'b0100, 4'b0000, 64'h0, R0, 4, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b1, 64'h2048, W1, 1, R1, 4'b0010, 4'b1101, 64'h2040, R0, 3, 1'b1};
    vecs[2] = '{3, 1'b0, 1'b1, 64'h3FFF, W2, 3, R1, 4'b1000, 4'b0111, 64'h3FE0, R0, 5, 1'b1};
    vecs[3] = '{0, 1'b1, 1'b0, 64'h0040, '0, 1, R1, 4'b0001, 4'b0000, 64'h0, R1, 3, 1'b0};
    vecs[4] = '{0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, W3, 2, R0, 4'b0001, 4'b1110,
                64'hFFFF_FFFF_FFFF_FFE0, R1, 4, 1'b1};
    vecs[5] = '{2, 1'b1, 1'b1, 64'h5010, W4, 1, R0, 4'b0100, 4'b1011, 64'h5000, R1, 3, 1'b1};

    // Reset values while rst is held.
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_h_dv", bus.h_dv, 0);
    check("rst_h_inv", bus.h_inv, 0);
    check("rst_h_amo_ack", bus.h_amo_ack, 0);
    check("rst_m_rd", bus.m_rd, 0);
    check("rst_m_wr", bus.m_wr, 0);
    check("rst_h_data_in", bus.h_data_in, 0);
    check("rst_h_inv_addr", bus.h_inv_addr, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_data_out", bus.m_data_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Round-robin with all harts requesting continuously.
    do_reset();
    for (int h = 0; h < 4; h++) bus.h_addr[h*AW +: AW] = 64'h100 * (h + 1);
    mem_lat   = 1;
    mem_rdata = R0;
    bus.h_rd  = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_dv(cyc);
      check($sformatf("rr_grant%0d", g), bus.h_dv, 4'b0001 << (g % 4));
    end
    bus.h_rd = '0;
    @(posedge clk);
    #1;

    // AMO lock taken by hart 3 while hart 0's read is outstanding.
    do_reset();
    for (int h = 0; h < 4; h++) bus.h_addr[h*AW +: AW] = 64'h1000 * (h + 1);
    mem_lat  = 4;
    bus.h_rd[0] = 1'b1;
    @(posedge clk);
    #1;
    check("amo_h0_in_req", bus.m_rd, 1);
    bus.h_amo_req[3] = 1'b1;
    @(posedge clk);
    #1;
    check("amo_ack_h3", bus.h_amo_ack, 4'b1000);
    bus.h_rd[1] = 1'b1;
    bus.h_rd[3] = 1'b1;
    wait_dv(cyc);
    check("amo_h0_done", bus.h_dv, 4'b0001);
    wait_dv(cyc);
    check("amo_locked_1", bus.h_dv, 4'b1000);
    wait_dv(cyc);
    check("amo_locked_2", bus.h_dv, 4'b1000);
    bus.h_amo_req = '0;
    bus.h_rd[3]   = 1'b0;
    @(posedge clk);
    #1;
    check("amo_release", bus.h_amo_ack, 0);
    wait_dv(cyc);
    check("amo_after_unlock", (bus.h_dv == 4'b0001) || (bus.h_dv == 4'b0010), 1);
    bus.h_rd = '0;
    @(posedge clk);
    #1;

    // Simultaneous lock requests from harts 1 and 2 with rr_ptr at 2.
    do_reset();
    mem_lat = 1;
    bus.h_rd[1] = 1'b1;
    wait_dv(cyc);
    check("simul_setup_h1", bus.h_dv, 4'b0010);
    bus.h_rd = '0;
    @(posedge clk);
    #1;
    bus.h_amo_req = 4'b0110;
    @(posedge clk);
    #1;
    check("simul_owner", bus.h_amo_ack, 4'b0100);
    @(posedge clk);
    #1;
    check("simul_hold", bus.h_amo_ack, 4'b0100);
    bus.h_amo_req[2] = 1'b0;
    @(posedge clk);
    #1;
    check("simul_release", bus.h_amo_ack, 0);
    @(posedge clk);
    #1;
    check("simul_h1_ack", bus.h_amo_ack, 4'b0010);

    // Reset in the middle of a write by the lock owner, rr_ptr currently 2.
    bus.h_addr[1*AW +: AW] = 64'h7000;
    bus.h_wr[1] = 1'b1;
    mem_lat = 20;
    @(posedge clk);
    #1;
    check("rst_mid_m_wr_before", bus.m_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_m_wr", bus.m_wr, 0);
    check("rst_mid_h_dv", bus.h_dv, 0);
    check("rst_mid_h_inv", bus.h_inv, 0);
    check("rst_mid_amo_ack", bus.h_amo_ack, 0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 1;
    bus.h_rd = 4'b1111;
    wait_dv(cyc);
    check("rst_rr_ptr_zero", bus.h_dv, 4'b0001);
    check("rst_idle_latency", cyc, 3);
    bus.h_rd = '0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
